// File: rtl/leitor_registrador7b.sv
// leitor_registrador7b: read-side companion of the 7-bit register bank.
// On a read request it snapshots the selected register word and sends it
// LSB-first over a valid/accept handshake. When the last bit is accepted it
// pulses fim for one cycle. The captured word is also held on dado_lido.
// Optional feature macro: PARIDADE_EN. When it is defined, an even-parity bit
// is sent after the data MSB.
module leitor_registrador7b #(
    parameter int LARGURA = 7,
    parameter int SEL_W   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LARGURA*(2**SEL_W)-1:0]   valores_registrador,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            sinal,
    input  logic                            aceita,
    output logic                            bit_saida,
    output logic                            bit_valido,
    output logic                            ocupado,
    output logic                            fim,
    output logic [LARGURA-1:0]              dado_lido
);

    localparam int NUM_REG = 2**SEL_W;
`ifdef PARIDADE_EN
    localparam int NBITS = LARGURA + 1;
`else
    localparam int NBITS = LARGURA;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ENVIO  = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t             state_reg, state_next;
    logic [NBITS-1:0]    shift_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [LARGURA-1:0]  dado_reg;
    logic                captura;
    logic                avanca;

    // Split the flattened bank into one word per register.
    logic [LARGURA-1:0]  banco [NUM_REG];
    generate
        for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_banco
            assign banco[gi] = valores_registrador[gi*LARGURA +: LARGURA];
        end
    endgenerate

    logic [LARGURA-1:0]  palavra_sel;
    logic [NBITS-1:0]    carga;
    assign palavra_sel = banco[sel];
`ifdef PARIDADE_EN
    // The parity bit sits above the MSB, so it leaves the shifter last.
    assign carga = {^palavra_sel, palavra_sel};
`else
    assign carga = palavra_sel;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= OCIOSO;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the capture/advance strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        captura    = 1'b0;
        avanca     = 1'b0;
        case (state_reg)
            OCIOSO: begin
                if (sinal) begin
                    captura    = 1'b1;
                    state_next = ENVIO;
                end
            end
            ENVIO: begin
                if (aceita) begin
                    avanca = 1'b1;
                    if (cnt_reg == ULTIMO) begin
                        state_next = FIM;
                    end
                end
            end
            FIM: begin
                state_next = OCIOSO;
            end
            default: begin
                state_next = OCIOSO;
            end
        endcase
    end

    // Snapshot on capture. Shift one bit per accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            dado_reg  <= '0;
        end else if (captura) begin
            shift_reg <= carga;
            cnt_reg   <= '0;
            dado_reg  <= palavra_sel;
        end else if (avanca) begin
            shift_reg <= shift_reg >> 1;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    // All outputs are decoded from registered state, so neither sinal nor
    // aceita has a combinational path to an output.
    assign bit_valido = (state_reg == ENVIO);
    assign bit_saida  = (state_reg == ENVIO) & shift_reg[0];
    assign ocupado    = (state_reg == ENVIO) | (state_reg == FIM);
    assign fim        = (state_reg == FIM);
    assign dado_lido  = dado_reg;

endmodule
